// File: rtl/cw305_usb_pkg.sv
// Shared types and constants for the CW305 USB register-bus initiator.
package cw305_usb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESP   = 3'd4,
        ST_TURN   = 3'd5
    } usb_state_e;

    localparam logic USB_CEN_IDLE = 1'b1;
    localparam logic USB_RDN_IDLE = 1'b1;
    localparam logic USB_WRN_IDLE = 1'b1;
    localparam logic USB_OE_IDLE  = 1'b0;

    localparam int PHASE_CNT_W = 8;

    function automatic int byte_data_w(input int bytecnt_size);
        return 32'sd8 * (32'sd1 << bytecnt_size);
    endfunction

endpackage

// File: rtl/cw305_usb_phase_cnt.sv
// Loadable down-counter timing the SETUP/STROBE/HOLD phases; o_term flags the last cycle.
module cw305_usb_phase_cnt
    import cw305_usb_pkg::*;
#(
    parameter int CNT_W = PHASE_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_term
);

    logic [CNT_W-1:0] r_cnt;

    // count down to zero, reloading when a new phase starts
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != {CNT_W{1'b0}}) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_term = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/cw305_usb_initiator.sv
// Host-side initiator: word register requests become byte-wide cen/rdn/wrn cycles.
// Defining CW305_USB_TRIGGER_EN adds the usb_trigger_o pulse driven from req_trig_i.
module cw305_usb_initiator
    import cw305_usb_pkg::*;
#(
    parameter int pBYTECNT_SIZE = 2,
    parameter int pADDR_WIDTH   = 21,
    parameter int SETUP_CYC     = 1,
    parameter int STROBE_CYC    = 2,
    parameter int HOLD_CYC      = 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic                                  req_we_i,
    input  logic [pADDR_WIDTH-1:0]                req_addr_i,
    input  logic [pBYTECNT_SIZE-1:0]              req_len_i,
    input  logic [byte_data_w(pBYTECNT_SIZE)-1:0] req_wdata_i,
    input  logic                                  req_trig_i,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic [byte_data_w(pBYTECNT_SIZE)-1:0] rsp_rdata_o,
    output logic [pADDR_WIDTH-1:0]                usb_addr_o,
    output logic [7:0]                            usb_data_o,
    output logic                                  usb_data_oe_o,
    input  logic [7:0]                            usb_data_i,
    output logic                                  usb_cen_o,
    output logic                                  usb_rdn_o,
    output logic                                  usb_wrn_o,
    output logic                                  usb_trigger_o
);

    localparam int DW = byte_data_w(pBYTECNT_SIZE);
    localparam int BC = pBYTECNT_SIZE;

    usb_state_e           r_state;
    logic                 r_we;
    logic [pADDR_WIDTH-1:0] r_addr;
    logic [BC-1:0]        r_len;
    logic [BC-1:0]        r_k;
    logic [DW-1:0]        r_wdata;
    logic [DW-1:0]        r_rdata;
    logic                 r_ready;
    logic                 r_rsp_valid;
    logic [pADDR_WIDTH-1:0] r_usb_addr;
    logic [7:0]           r_usb_data;
    logic                 r_oe;
    logic                 r_cen;
    logic                 r_rdn;
    logic                 r_wrn;

    usb_state_e           w_state_next;
    logic                 w_we_next;
    logic [pADDR_WIDTH-1:0] w_addr_next;
    logic [BC-1:0]        w_len_next;
    logic [BC-1:0]        w_k_next;
    logic [DW-1:0]        w_wdata_next;
    logic [DW-1:0]        w_rdata_next;
    logic                 w_accept;
    logic                 w_bus_active;
    logic [pADDR_WIDTH-1:0] w_byte_addr;
    logic                 w_phase_load;
    logic [PHASE_CNT_W-1:0] w_phase_val;
    logic                 w_phase_term;

    cw305_usb_phase_cnt #(
        .CNT_W (PHASE_CNT_W)
    ) u_phase_cnt (
        .i_clk      (clk_i),
        .i_rst_n    (rst_ni),
        .i_load     (w_phase_load),
        .i_load_val (w_phase_val),
        .o_term     (w_phase_term)
    );

    // next-state and transaction-context update
    always_comb begin
        w_state_next = r_state;
        w_we_next    = r_we;
        w_addr_next  = r_addr;
        w_len_next   = r_len;
        w_k_next     = r_k;
        w_wdata_next = r_wdata;
        w_rdata_next = r_rdata;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid_i && r_ready) begin
                    w_accept     = 1'b1;
                    w_we_next    = req_we_i;
                    w_addr_next  = req_addr_i;
                    w_len_next   = req_len_i;
                    w_wdata_next = req_wdata_i;
                    w_k_next     = {BC{1'b0}};
                    w_rdata_next = {DW{1'b0}};
                    w_state_next = ST_SETUP;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (w_phase_term) begin
                    w_state_next = ST_STROBE;
                end else begin
                    w_state_next = ST_SETUP;
                end
            end
            ST_STROBE: begin
                if (w_phase_term) begin
                    if (!r_we) begin
                        w_rdata_next[{r_k, 3'b000} +: 8] = usb_data_i;
                    end else begin
                        w_rdata_next = r_rdata;
                    end
                    w_state_next = ST_HOLD;
                end else begin
                    w_state_next = ST_STROBE;
                end
            end
            ST_HOLD: begin
                if (!w_phase_term) begin
                    w_state_next = ST_HOLD;
                end else if (r_k != r_len) begin
                    w_k_next     = r_k + BC'(1);
                    w_state_next = ST_SETUP;
                end else begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    w_state_next = ST_TURN;
                end else begin
                    w_state_next = ST_RESP;
                end
            end
            ST_TURN: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // phase counter reloads with the length of whichever phase is entered next
    always_comb begin
        w_phase_load = (w_state_next != r_state);
        case (w_state_next)
            ST_SETUP:  w_phase_val = PHASE_CNT_W'(SETUP_CYC - 1);
            ST_STROBE: w_phase_val = PHASE_CNT_W'(STROBE_CYC - 1);
            ST_HOLD:   w_phase_val = PHASE_CNT_W'(HOLD_CYC - 1);
            default:   w_phase_val = {PHASE_CNT_W{1'b0}};
        endcase
    end

    assign w_bus_active = (w_state_next == ST_SETUP) || (w_state_next == ST_STROBE) ||
                          (w_state_next == ST_HOLD);
    // byte-select field wraps inside the word; upper address bits never change
    assign w_byte_addr  = {w_addr_next[pADDR_WIDTH-1:BC], w_addr_next[BC-1:0] + w_k_next};

    // transaction context registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_addr  <= {pADDR_WIDTH{1'b0}};
            r_len   <= {BC{1'b0}};
            r_k     <= {BC{1'b0}};
            r_wdata <= {DW{1'b0}};
            r_rdata <= {DW{1'b0}};
        end else begin
            r_state <= w_state_next;
            r_we    <= w_we_next;
            r_addr  <= w_addr_next;
            r_len   <= w_len_next;
            r_k     <= w_k_next;
            r_wdata <= w_wdata_next;
            r_rdata <= w_rdata_next;
        end
    end

    // outputs registered from the upcoming state so they line up with it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_usb_addr  <= {pADDR_WIDTH{1'b0}};
            r_usb_data  <= 8'h00;
            r_oe        <= USB_OE_IDLE;
            r_cen       <= USB_CEN_IDLE;
            r_rdn       <= USB_RDN_IDLE;
            r_wrn       <= USB_WRN_IDLE;
        end else begin
            r_ready     <= (w_state_next == ST_IDLE);
            r_rsp_valid <= (w_state_next == ST_RESP);
            r_cen       <= w_bus_active ? 1'b0 : USB_CEN_IDLE;
            r_rdn       <= ((w_state_next == ST_STROBE) && !w_we_next) ? 1'b0 : USB_RDN_IDLE;
            r_wrn       <= ((w_state_next == ST_STROBE) && w_we_next) ? 1'b0 : USB_WRN_IDLE;
            r_oe        <= (w_bus_active && w_we_next) ? 1'b1 : USB_OE_IDLE;
            if (w_bus_active) begin
                r_usb_addr <= w_byte_addr;
                if (w_we_next) begin
                    r_usb_data <= w_wdata_next[{w_k_next, 3'b000} +: 8];
                end
            end
        end
    end

    assign req_ready_o   = r_ready;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rdata;
    assign usb_addr_o    = r_usb_addr;
    assign usb_data_o    = r_usb_data;
    assign usb_data_oe_o = r_oe;
    assign usb_cen_o     = r_cen;
    assign usb_rdn_o     = r_rdn;
    assign usb_wrn_o     = r_wrn;

`ifdef CW305_USB_TRIGGER_EN
    logic r_trig_en;
    logic r_trigger;

    // trigger spans first strobe through last hold, including inter-byte setups
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_trig_en <= 1'b0;
            r_trigger <= 1'b0;
        end else begin
            if (w_accept) begin
                r_trig_en <= req_trig_i;
            end
            r_trigger <= r_trig_en && ((w_state_next == ST_STROBE) || (w_state_next == ST_HOLD) ||
                         ((w_state_next == ST_SETUP) && (r_state == ST_HOLD)));
        end
    end

    assign usb_trigger_o = r_trigger;
`else
    logic w_trig_unused;
    assign w_trig_unused = req_trig_i ^ w_accept;
    assign usb_trigger_o = 1'b0;
`endif

endmodule

// File: tb/tb_cw305_usb_initiator.sv
// Scoreboard bench for cw305_usb_initiator: bus beats and responses queued at stimulus time.
module tb_cw305_usb_initiator;

    localparam int SETUP_CYC  = 1;
    localparam int STROBE_CYC = 2;
    localparam int HOLD_CYC   = 1;
    localparam int PH         = SETUP_CYC + STROBE_CYC + HOLD_CYC;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [20:0] req_addr_i = 21'd0;
    logic [1:0]  req_len_i = 2'd0;
    logic [31:0] req_wdata_i = 32'd0;
    logic        req_trig_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic [20:0] usb_addr_o;
    logic [7:0]  usb_data_o;
    logic        usb_data_oe_o;
    logic [7:0]  usb_data_i;
    logic        usb_cen_o;
    logic        usb_rdn_o;
    logic        usb_wrn_o;
    logic        usb_trigger_o;

    typedef struct {
        logic [20:0] addr;
        logic        we;
        logic [7:0]  data;
    } beat_t;

    beat_t       beat_q[$];
    logic [31:0] rsp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    cw305_usb_initiator #(
        .pBYTECNT_SIZE (2),
        .pADDR_WIDTH   (21),
        .SETUP_CYC     (SETUP_CYC),
        .STROBE_CYC    (STROBE_CYC),
        .HOLD_CYC      (HOLD_CYC)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_we_i      (req_we_i),
        .req_addr_i    (req_addr_i),
        .req_len_i     (req_len_i),
        .req_wdata_i   (req_wdata_i),
        .req_trig_i    (req_trig_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .usb_addr_o    (usb_addr_o),
        .usb_data_o    (usb_data_o),
        .usb_data_oe_o (usb_data_oe_o),
        .usb_data_i    (usb_data_i),
        .usb_cen_o     (usb_cen_o),
        .usb_rdn_o     (usb_rdn_o),
        .usb_wrn_o     (usb_wrn_o),
        .usb_trigger_o (usb_trigger_o)
    );

    always #5 clk_i = ~clk_i;

    // register-bridge model: byte depends on byte-select and some upper address bits
    function automatic logic [7:0] rd_model(input logic [20:0] a);
        logic [7:0] base;
        case (a[1:0])
            2'd0:    base = 8'h33;
            2'd1:    base = 8'h44;
            2'd2:    base = 8'h11;
            default: base = 8'h22;
        endcase
        return base ^ a[9:2];
    endfunction

    always_comb usb_data_i = usb_rdn_o ? 8'h00 : rd_model(usb_addr_o);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // pop one expected beat at every strobe start
    logic prev_rdn = 1'b1;
    logic prev_wrn = 1'b1;
    always @(negedge clk_i) begin
        beat_t b;
        if (!rst_ni) begin
            prev_rdn = 1'b1;
            prev_wrn = 1'b1;
        end else begin
            chk("strobe_excl", 64'(usb_rdn_o | usb_wrn_o), 64'd1);
            if ((!usb_rdn_o && prev_rdn) || (!usb_wrn_o && prev_wrn)) begin
                if (beat_q.size() == 0) begin
                    chk("beat_unexpected", 64'd1, 64'd0);
                end else begin
                    b = beat_q.pop_front();
                    chk("beat_addr", 64'(usb_addr_o), 64'(b.addr));
                    chk("beat_we", 64'(!usb_wrn_o), 64'(b.we));
                    if (b.we) chk("beat_data", 64'(usb_data_o), 64'(b.data));
                end
            end
            prev_rdn = usb_rdn_o;
            prev_wrn = usb_wrn_o;
        end
    end

    task automatic push_expect(input logic we, input logic [20:0] addr, input logic [1:0] len,
                               input logic [31:0] wdata);
        beat_t       b;
        logic [31:0] exp_rd = 32'd0;
        for (int k = 0; k <= int'(len); k++) begin
            b.addr = {addr[20:2], addr[1:0] + 2'(k)};
            b.we   = we;
            b.data = wdata[8*k +: 8];
            beat_q.push_back(b);
            if (!we) exp_rd[8*k +: 8] = rd_model(b.addr);
        end
        rsp_q.push_back(exp_rd);
    endtask

    // wait for ready, present the request, return at the first cycle after acceptance
    task automatic issue(input logic we, input logic [20:0] addr, input logic [1:0] len,
                         input logic [31:0] wdata, input logic trig);
        int waited = 0;
        while (req_ready_o !== 1'b1 && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        chk("req_ready_idle", 64'(req_ready_o), 64'd1);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_len_i   = len;
        req_wdata_i = wdata;
        req_trig_i  = trig;
        @(negedge clk_i);
    endtask

    task automatic run_txn(input logic we, input logic [20:0] addr, input logic [1:0] len,
                           input logic [31:0] wdata, input logic trig, input int bp);
        int          n;
        logic [31:0] exp_rd;
        push_expect(we, addr, len, wdata);
        issue(we, addr, len, wdata, trig);
        n = (int'(len) + 1) * PH;
        for (int c = 1; c <= n; c++) begin
            int          p;
            int          kk;
            logic        strb;
            logic        exp_trig;
            logic [20:0] ea;
            p    = (c - 1) % PH;
            kk   = (c - 1) / PH;
            strb = (p >= SETUP_CYC) && (p < SETUP_CYC + STROBE_CYC);
            ea   = {addr[20:2], addr[1:0] + 2'(kk)};
`ifdef CW305_USB_TRIGGER_EN
            exp_trig = trig && (c > SETUP_CYC);
`else
            exp_trig = 1'b0;
`endif
            chk("cen_low", 64'(usb_cen_o), 64'd0);
            chk("rdn", 64'(usb_rdn_o), 64'(!(strb && !we)));
            chk("wrn", 64'(usb_wrn_o), 64'(!(strb && we)));
            chk("oe", 64'(usb_data_oe_o), 64'(we));
            chk("addr", 64'(usb_addr_o), 64'(ea));
            if (we) chk("wdata", 64'(usb_data_o), 64'(wdata[8*kk +: 8]));
            chk("req_ready_busy", 64'(req_ready_o), 64'd0);
            chk("rsp_early", 64'(rsp_valid_o), 64'd0);
            chk("trigger", 64'(usb_trigger_o), 64'(exp_trig));
            // junk requests while busy must be ignored
            req_valid_i = (c < n);
            req_we_i    = 1'($urandom);
            req_addr_i  = 21'($urandom);
            req_len_i   = 2'($urandom);
            req_wdata_i = $urandom;
            req_trig_i  = 1'($urandom);
            @(negedge clk_i);
        end
        chk("rsp_latency", 64'(rsp_valid_o), 64'd1);
        if (rsp_q.size() == 0) begin
            chk("rsp_q_empty", 64'd1, 64'd0);
            exp_rd = 32'd0;
        end else begin
            exp_rd = rsp_q.pop_front();
        end
        chk("rsp_rdata", 64'(rsp_rdata_o), 64'(exp_rd));
        chk("resp_cen", 64'(usb_cen_o), 64'd1);
        chk("resp_oe", 64'(usb_data_oe_o), 64'd0);
        chk("resp_trigger", 64'(usb_trigger_o), 64'd0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk_i);
            chk("bp_valid", 64'(rsp_valid_o), 64'd1);
            chk("bp_rdata", 64'(rsp_rdata_o), 64'(exp_rd));
            chk("bp_ready", 64'(req_ready_o), 64'd0);
            chk("bp_bus", 64'({usb_cen_o, usb_rdn_o, usb_wrn_o, usb_data_oe_o}), 64'd14);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        chk("turn_valid", 64'(rsp_valid_o), 64'd0);
        chk("turn_ready", 64'(req_ready_o), 64'd0);
        chk("turn_cen", 64'(usb_cen_o), 64'd1);
        @(negedge clk_i);
        chk("idle_ready", 64'(req_ready_o), 64'd1);
    endtask

    task automatic chk_idle_bus(input string tag);
        chk(tag, 64'({usb_cen_o, usb_rdn_o, usb_wrn_o, usb_data_oe_o, rsp_valid_o, req_ready_o}),
            64'b111000);
    endtask

    initial begin
        #12;
        chk_idle_bus("reset_bus");
        chk("reset_addr", 64'(usb_addr_o), 64'd0);
        chk("reset_data", 64'(usb_data_o), 64'd0);
        chk("reset_rdata", 64'(rsp_rdata_o), 64'd0);
        chk("reset_trigger", 64'(usb_trigger_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("ready_after_reset", 64'(req_ready_o), 64'd1);

        run_txn(1'b1, 21'h000400, 2'd3, 32'hDEADBEEF, 1'b0, 0);
        run_txn(1'b0, 21'h000402, 2'd1, 32'h0, 1'b0, 0);
        chk("read_plan_value", 64'(rsp_rdata_o), 64'h0000_2211);
        run_txn(1'b0, 21'h0155A7, 2'd2, 32'h0, 1'b0, 0);
        run_txn(1'b0, 21'h00A0F1, 2'd3, 32'h0, 1'b0, 10);
        run_txn(1'b1, 21'h000010, 2'd0, 32'h0000005C, 1'b1, 0);
        run_txn(1'b1, 21'h1FFFFE, 2'd2, 32'h00C0FFEE, 1'b1, 2);

        // reset during the strobe of byte 1 of a two-byte read
        push_expect(1'b0, 21'h000800, 2'd1, 32'd0);
        issue(1'b0, 21'h000800, 2'd1, 32'd0, 1'b1);
        req_valid_i = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("pre_reset_rdn", 64'(usb_rdn_o), 64'd0);
        #2 rst_ni = 1'b0;
        #1;
        chk_idle_bus("midreset_bus");
        chk("midreset_trigger", 64'(usb_trigger_o), 64'd0);
        rsp_q.delete();
        chk("beats_before_reset", 64'(beat_q.size()), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("ready_after_midreset", 64'(req_ready_o), 64'd1);
        chk("no_stale_rsp", 64'(rsp_valid_o), 64'd0);

        run_txn(1'b1, 21'h000123, 2'd1, 32'h0000A55A, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            run_txn(1'($urandom), 21'($urandom), 2'($urandom), $urandom, 1'($urandom),
                    int'($urandom_range(0, 3)));
        end
        chk("beats_drained", 64'(beat_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cw305_usb_initiator.md
Name: cw305_usb_initiator

Overview:
Synthesizable host-side initiator for the CW305 parallel USB register interface. It accepts word-level register read/write requests on a valid/ready port and sequences them as byte-wide chip-enable/read-strobe/write-strobe cycles on the external bus, with programmable setup, strobe and hold timing. It replaces hand-written bus tasks in system benches and allows on-board loopback of the USB register bridge.

Parameters:
pBYTECNT_SIZE, 2, width of the byte-select field in the bus address; max transfer 2^pBYTECNT_SIZE bytes
pADDR_WIDTH, 21, bus address width
SETUP_CYC, 1, cycles with cen low and addr/data stable before the strobe (>=1)
STROBE_CYC, 2, cycles with rdn/wrn low (>=1)
HOLD_CYC, 1, cycles after the strobe with addr/data held (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_we_i  in  1  1=write, 0=read
req_addr_i  in  pADDR_WIDTH  base bus address
req_len_i  in  pBYTECNT_SIZE  byte count minus 1
req_wdata_i  in  8*2^pBYTECNT_SIZE  write data, byte k at bits [8k+7:8k]
req_trig_i  in  1  request trigger pulse (optional feature)
rsp_valid_o  out  1  transaction complete
rsp_ready_i  in  1  response consumed
rsp_rdata_o  out  8*2^pBYTECNT_SIZE  read data, unused bytes zero
usb_addr_o  out  pADDR_WIDTH  bus address
usb_data_o  out  8  bus write data
usb_data_oe_o  out  1  data driver enable (top-level tristate)
usb_data_i  in  8  bus read data
usb_cen_o  out  1  active-low chip enable
usb_rdn_o  out  1  active-low read strobe
usb_wrn_o  out  1  active-low write strobe
usb_trigger_o  out  1  trigger line

Behaviour:
- Reset: req_ready_o=0 during reset, 1 from first cycle after release; rsp_valid_o=0, rsp_rdata_o=0, usb_addr_o=0, usb_data_o=0, usb_data_oe_o=0, usb_cen_o=1, usb_rdn_o=1, usb_wrn_o=1, usb_trigger_o=0; FSM to IDLE.
- FSM: IDLE -> SETUP -> STROBE -> HOLD -> (SETUP next byte | RESP) -> TURN -> IDLE.
- IDLE: req_ready_o=1. On accept, latch we/addr/len/wdata/trig, byte index k=0, clear rdata; next cycle SETUP.
- SETUP: cen=0, addr valid, strobes high; write: data_o=byte k, oe=1. SETUP_CYC cycles.
- STROBE: rdn (read) or wrn (write) low for STROBE_CYC cycles; read samples usb_data_i into rdata byte k on the last strobe cycle.
- HOLD: strobes high, cen/addr/data/oe held, HOLD_CYC cycles; then k<len: k++, SETUP; else RESP.
- Byte address: upper pADDR_WIDTH-pBYTECNT_SIZE bits = base; lower field = (base_low + k) mod 2^pBYTECNT_SIZE (wraps, no carry into upper bits).
- cen stays low across all bytes of one transaction; rdn/wrn never low simultaneously; oe never 1 on reads.
- RESP: cen=1, oe=0, rsp_valid_o=1 held with rsp_rdata_o stable until rsp_ready_i; writes return rdata=0.
- TURN: one mandatory idle cycle (cen=1) before IDLE; req_ready_o=0 everywhere except IDLE.
- Per-transaction latency (rsp_valid rise after accept) = 1 + (len+1)*(SETUP_CYC+STROBE_CYC+HOLD_CYC) cycles.
- Reset mid-transaction: bus returns to idle levels immediately (asynchronous); pending response discarded.
- Request inputs ignored outside IDLE.

Optional Feature:
CW305_USB_TRIGGER_EN: defined -> usb_trigger_o high from first STROBE cycle to last HOLD cycle of a transaction accepted with req_trig_i=1, else 0. Undefined -> usb_trigger_o tied 0, req_trig_i unused, no trigger register.

Decomposition:
- Package cw305_usb_pkg: FSM state enum, bus idle-level constants, byte-data width function 8*2^pBYTECNT_SIZE.
- One sub-module: cw305_usb_phase_cnt (loadable down-counter with terminal flag), shared by SETUP/STROBE/HOLD.

Test Plan:
- Write addr=0x000400, len=3, wdata=0xDEADBEEF -> four wrn pulses at addr low bits 0,1,2,3 with data EF,BE,AD,DE; cen low throughout; rsp_valid after 1+4*4=17 cycles.
- Read addr=0x000402, len=1, bus model returns 0x11,0x22 -> addr low bits 2,3; rsp_rdata=0x00002211; oe never 1.
- Wrap: read base low bits=3, len=2 -> byte addresses low bits 3,0,1, upper bits unchanged.
- Back-pressure: hold rsp_ready_i=0 for 10 cycles -> rsp_valid/rdata stable, req_ready=0, no bus activity; after ready, one TURN cycle then req_ready=1.
- Reset asserted in STROBE of byte 1 -> same cycle cen/rdn/wrn=1, oe=0, rsp_valid=0; next request after release completes normally.
- With CW305_USB_TRIGGER_EN, req_trig_i=1 single-byte write -> trigger high exactly STROBE_CYC+HOLD_CYC=3 cycles; without macro trigger stays 0.
